// File: rtl/col_parity_frame_pkg.sv
// Shared constants, FSM state type and the column-parity helper
// used by the col_parity_frame encoder and its theta datapath.
package col_parity_frame_pkg;

  localparam int SLICE_W    = 25;
  localparam int ROW        = 5;
  localparam int NSLICE_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Column x parity: XOR of the five lanes (x, y=0..4).
  function automatic logic [ROW-1:0] col_par(
    input logic [SLICE_W-1:0] s
  );
    logic [ROW-1:0] p;
    p = '0;
    for (int y = 0; y < ROW; y++) begin
      p = p ^ s[y*ROW +: ROW];
    end
    return p;
  endfunction

endpackage

// File: rtl/col_parity_frame_theta.sv
// slice_theta: combinational theta step for one 25-bit slice.
// Ports: i_slice (slice A[z]), i_par (C[z]), i_prev_par (C[z-1]),
//        o_slice (encoded E[z]).
module slice_theta
  import col_parity_frame_pkg::*;
(
  input  logic [SLICE_W-1:0] i_slice,
  input  logic [ROW-1:0]     i_par,
  input  logic [ROW-1:0]     i_prev_par,
  output logic [SLICE_W-1:0] o_slice
);

  logic [ROW-1:0] w_d;

  // Per-column mask: left neighbour in this slice,
  // right neighbour in the previous slice.
  for (genvar x = 0; x < ROW; x++) begin : g_d
    assign w_d[x] = i_par[(x+4)%ROW]
                  ^ i_prev_par[(x+1)%ROW];
  end

  for (genvar y = 0; y < ROW; y++) begin : g_row
    assign o_slice[y*ROW +: ROW] =
      i_slice[y*ROW +: ROW] ^ w_d;
  end

endmodule

// File: rtl/col_parity_frame.sv
// col_parity_frame: buffers a frame of NSLICE slices with their column
// parities, then streams out the theta-encoded slices z=0..NSLICE-1.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_slice load
// side; out_valid/out_ready/out_slice/out_index/out_last emit side;
// busy high while loading or emitting.
module col_parity_frame
  import col_parity_frame_pkg::*;
#(
  parameter int NSLICE = NSLICE_DEF,
  parameter int IW     = $clog2(NSLICE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic [IW-1:0]      out_index,
  output logic               out_last,
  output logic               busy
);

  state_t             r_state;
  logic [IW-1:0]      r_wptr;
  logic [IW-1:0]      r_rptr;
  logic [SLICE_W-1:0] r_mem [NSLICE];
  logic [ROW-1:0]     r_par [NSLICE];

  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_wlast;
  logic               w_rlast;
  logic [IW-1:0]      w_prev_idx;
  logic [SLICE_W-1:0] w_enc;

  assign in_ready   = (r_state != ST_EMIT);
  assign out_valid  = (r_state == ST_EMIT);
  assign busy       = (r_state != ST_IDLE);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_wlast    = (r_wptr == IW'(NSLICE-1));
  assign w_rlast    = (r_rptr == IW'(NSLICE-1));
  // Power-of-two depth: modular wrap gives z-1 for z=0.
  assign w_prev_idx = r_rptr - 1'b1;

  assign out_index = r_rptr;
  assign out_last  = out_valid & w_rlast;
  // Arrays are unreset, so keep the output bus quiet
  // outside EMIT.
  assign out_slice = out_valid ? w_enc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_in_fire) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_out_fire) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_in_fire) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_in_fire && w_wlast) r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (w_out_fire && w_rlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wptr] <= in_slice;
      r_par[r_wptr] <= col_par(in_slice);
    end
  end

  slice_theta u_theta (
    .i_slice    (r_mem[r_rptr]),
    .i_par      (r_par[r_rptr]),
    .i_prev_par (r_par[w_prev_idx]),
    .o_slice    (w_enc)
  );

endmodule

// File: tb/tb_col_parity_frame.sv
// Self-checking bench for col_parity_frame (NSLICE=64): directed
// single-bit frames, random gapped/stalled frames, resets, back-to-back.
module tb_col_parity_frame;

  localparam int NS = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [24:0]   in_slice;
  logic          out_valid;
  logic          out_ready;
  logic [24:0]   out_slice;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  col_parity_frame #(.NSLICE(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [24:0] frame [NS];
  logic [24:0] nxt   [NS];
  logic [24:0] got   [NS];

  typedef struct {
    int          sz;
    logic [24:0] sv;
    int          cz;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference theta written bit-by-bit from the lane definition.
  function automatic logic [24:0] model(input int z);
    int          zp;
    int          x;
    logic        b;
    logic [24:0] e;
    zp = (z + NS - 1) % NS;
    for (int i = 0; i < 25; i++) begin
      x = i % 5;
      b = frame[z][i];
      for (int y = 0; y < 5; y++) begin
        b = b ^ frame[z][5*y + (x+4)%5]
              ^ frame[zp][5*y + (x+1)%5];
      end
      e[i] = b;
    end
    return e;
  endfunction

  task automatic send_frame(input int start, input int limit,
                            input bit gaps);
    int i;
    int guard;
    i = start;
    guard = 0;
    while (i < limit && guard < 4000) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_slice  = frame[i];
      #1;
      chk("load_out_valid", {31'd0, out_valid}, 32'd0);
      if (in_valid && in_ready) i++;
      guard++;
    end
    if (i < limit) chk("send_timeout", i, limit);
  endtask

  task automatic recv_frame(input bit stalls, input bit keep_in,
                            input int limit, input bit first_now);
    int            n;
    int            guard;
    bit            held;
    logic [24:0]   hs;
    logic [IW-1:0] hi;
    n = 0;
    guard = 0;
    held = 0;
    hs = '0;
    hi = '0;
    while (n < limit && guard < 4000) begin
      @(negedge clk);
      in_valid  = keep_in;
      in_slice  = nxt[0];
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (first_now && guard == 0)
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
      if (held) begin
        chk("stall_slice", {7'd0, out_slice}, {7'd0, hs});
        chk("stall_index", {26'd0, out_index}, {26'd0, hi});
      end
      held = 0;
      if (out_valid) begin
        chk($sformatf("index_%0d", n), {26'd0, out_index}, n);
        chk($sformatf("last_%0d", n), {31'd0, out_last},
            {31'd0, n == NS-1});
        chk("emit_in_ready", {31'd0, in_ready}, 32'd0);
        if (out_ready) begin
          got[n] = out_slice;
          n++;
        end else begin
          held = 1;
          hs = out_slice;
          hi = out_index;
        end
      end
      guard++;
    end
    if (n < limit) chk("recv_timeout", n, limit);
  endtask

  task automatic end_idle();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame(input string name);
    for (int z = 0; z < NS; z++)
      chk($sformatf("%s_z%0d", name, z), {7'd0, got[z]},
          {7'd0, model(z)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0,  25'h0000000, 0,  25'h0000000};
    tbl[1]  = '{0,  25'h0000000, 63, 25'h0000000};
    tbl[2]  = '{0,  25'h0000001, 0,  25'h0210843};
    tbl[3]  = '{0,  25'h0000001, 1,  25'h1084210};
    tbl[4]  = '{0,  25'h0000001, 2,  25'h0000000};
    tbl[5]  = '{63, 25'h0000001, 0,  25'h1084210};
    tbl[6]  = '{63, 25'h0000001, 63, 25'h0210843};
    tbl[7]  = '{63, 25'h0000001, 62, 25'h0000000};
    tbl[8]  = '{5,  25'h0000080, 5,  25'h0842188};
    tbl[9]  = '{5,  25'h0000080, 6,  25'h0210842};
    tbl[10] = '{3,  25'h0000021, 3,  25'h0000021};
    tbl[11] = '{3,  25'h0000021, 4,  25'h0000000};

    for (int z = 0; z < NS; z++) nxt[z] = '0;

    rst = 1'b1;
    in_valid = 1'b0;
    in_slice = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_slice", {7'd0, out_slice}, 32'd0);
    chk("rst_out_index", {26'd0, out_index}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      for (int z = 0; z < NS; z++) frame[z] = '0;
      frame[tbl[r].sz] = tbl[r].sv;
      send_frame(0, NS, 0);
      recv_frame(0, 0, NS, 1);
      end_idle();
      chk($sformatf("tbl%0d_z%0d", r, tbl[r].cz),
          {7'd0, got[tbl[r].cz]}, {7'd0, tbl[r].exp});
      check_frame($sformatf("tbl%0d", r));
    end

    for (int z = 0; z < NS; z++) frame[z] = 25'($urandom);
    send_frame(0, NS, 1);
    recv_frame(1, 0, NS, 1);
    end_idle();
    check_frame("rand");

    for (int z = 0; z < NS; z++) frame[z] = 25'($urandom);
    send_frame(0, 30, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("midload_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstload_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstload_busy", {31'd0, busy}, 32'd0);
    chk("rstload_out_valid", {31'd0, out_valid}, 32'd0);
    for (int z = 0; z < NS; z++) frame[z] = 25'($urandom);
    send_frame(0, NS, 1);
    recv_frame(1, 0, NS, 1);
    end_idle();
    check_frame("post_rst_load");

    for (int z = 0; z < NS; z++) frame[z] = 25'($urandom);
    send_frame(0, NS, 0);
    recv_frame(0, 0, 10, 1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("emit_z10_index", {26'd0, out_index}, 32'd10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstemit_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstemit_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstemit_out_index", {26'd0, out_index}, 32'd0);
    chk("rstemit_out_slice", {7'd0, out_slice}, 32'd0);
    chk("rstemit_busy", {31'd0, busy}, 32'd0);

    for (int z = 0; z < NS; z++) begin
      frame[z] = 25'($urandom);
      nxt[z]   = 25'($urandom);
    end
    send_frame(0, NS, 0);
    recv_frame(0, 1, NS, 1);
    check_frame("b2b1");
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_slice  = nxt[0];
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
    for (int z = 0; z < NS; z++) frame[z] = nxt[z];
    send_frame(1, NS, 0);
    recv_frame(0, 0, NS, 1);
    end_idle();
    check_frame("b2b2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
